// File: rtl/prog_loader_if.sv
// Loader handshake and memory-load bus. The master (stream source / core side) drives start and the
// input stream; the slave (prog_loader) drives ready, the write port and the status outputs.
interface prog_loader_if;
   logic       start;
   logic [7:0] in_data;
   logic       in_valid;
   logic       in_ready;
   logic       ld_we;
   logic [6:0] ld_addr;
   logic [7:0] ld_data;
   logic       busy;
   logic       done;
   logic       err;
   logic [7:0] wr_count;

   modport master (
      output start, in_data, in_valid,
      input  in_ready, ld_we, ld_addr, ld_data, busy, done, err, wr_count
   );

   modport slave (
      input  start, in_data, in_valid,
      output in_ready, ld_we, ld_addr, ld_data, busy, done, err, wr_count
   );
endinterface

// File: rtl/prog_loader.sv
// Loads a length-prefixed, XOR-checksummed byte stream into instruction memory; a write appears the
// cycle after each accepted data byte. The loader is always ready while busy and simply waits on in_valid=0.
module prog_loader (
   input  logic          clk,
   input  logic          rst_n,
   prog_loader_if.slave  bus
);
   typedef enum logic [1:0] {IDLE, LEN, DATA, CHK} state_t;

   state_t     state_q, state_d;
   logic       in_ready_q, in_ready_d;
   logic       ld_we_q, ld_we_d;
   logic [6:0] ld_addr_q, ld_addr_d;
   logic [7:0] ld_data_q, ld_data_d;
   logic       busy_q, busy_d;
   logic       done_q, done_d;
   logic       err_q, err_d;
   logic [7:0] wr_count_q, wr_count_d;
   logic [7:0] csum_q, csum_d;
   logic [6:0] index_q, index_d;
   logic [7:0] len_q, len_d;
   logic       accept;

   assign accept = bus.in_valid & in_ready_q;

   always_comb begin
      state_d    = state_q;
      ld_we_d    = 1'b0;
      ld_addr_d  = ld_addr_q;
      ld_data_d  = ld_data_q;
      done_d     = 1'b0;
      err_d      = err_q;
      wr_count_d = wr_count_q;
      csum_d     = csum_q;
      index_d    = index_q;
      len_d      = len_q;

      case (state_q)
         IDLE: begin
            if (bus.start) begin
               state_d    = LEN;
               err_d      = 1'b0;
               wr_count_d = 8'd0;
               csum_d     = 8'd0;
            end
         end
         LEN: begin
            if (accept) begin
               if (bus.in_data != 8'd0 && bus.in_data <= 8'd128) begin
                  len_d   = bus.in_data;
                  index_d = 7'd0;
                  state_d = DATA;
               end else begin
                  err_d   = 1'b1;
                  state_d = IDLE;
               end
            end
         end
         DATA: begin
            if (accept) begin
               ld_we_d    = 1'b1;
               ld_addr_d  = index_q;
               ld_data_d  = bus.in_data;
               wr_count_d = wr_count_q + 8'd1;
               csum_d     = csum_q ^ bus.in_data;
               // index holds on the final byte so a 128-byte load never wraps it back to 0
               if (wr_count_q + 8'd1 == len_q) begin
                  state_d = CHK;
               end else begin
                  index_d = index_q + 7'd1;
               end
            end
         end
         CHK: begin
            if (accept) begin
               if (bus.in_data == csum_q) begin
                  done_d = 1'b1;
               end else begin
                  err_d  = 1'b1;
               end
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      busy_d     = (state_d != IDLE);
      in_ready_d = (state_d != IDLE);
   end

   always_ff @(posedge clk or posedge rst_n) begin
      if (rst_n) begin
         state_q    <= IDLE;
         in_ready_q <= 1'b0;
         ld_we_q    <= 1'b0;
         ld_addr_q  <= 7'd0;
         ld_data_q  <= 8'd0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
         wr_count_q <= 8'd0;
         csum_q     <= 8'd0;
         index_q    <= 7'd0;
         len_q      <= 8'd0;
      end else begin
         state_q    <= state_d;
         in_ready_q <= in_ready_d;
         ld_we_q    <= ld_we_d;
         ld_addr_q  <= ld_addr_d;
         ld_data_q  <= ld_data_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         err_q      <= err_d;
         wr_count_q <= wr_count_d;
         csum_q     <= csum_d;
         index_q    <= index_d;
         len_q      <= len_d;
      end
   end

   assign bus.in_ready = in_ready_q;
   assign bus.ld_we    = ld_we_q;
   assign bus.ld_addr  = ld_addr_q;
   assign bus.ld_data  = ld_data_q;
   assign bus.busy     = busy_q;
   assign bus.done     = done_q;
   assign bus.err      = err_q;
   assign bus.wr_count = wr_count_q;
endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: sessions with good/bad checksums, bad lengths, a full 128-byte
// load with valid gaps, mid-session reset and a stray start during DATA.
module tb_prog_loader;
   logic clk = 1'b0;
   logic rst_n;

   always #5 clk = ~clk;

   prog_loader_if bus();

   prog_loader dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;
   int ndone    = 0;
   int nboth    = 0;
   logic [6:0] wa[$];
   logic [7:0] wd[$];
   int         wc[$];

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (bus.ld_we) begin
         wa.push_back(bus.ld_addr);
         wd.push_back(bus.ld_data);
         wc.push_back(cyc);
      end
      if (bus.done) ndone++;
      if (bus.done && bus.err) nboth++;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [7:0] b);
      int t;
      t = 0;
      bus.in_valid = 1'b1;
      bus.in_data  = b;
      while (!bus.in_ready && t < 50) begin
         tick();
         t++;
      end
      if (!bus.in_ready) chk("ready_timeout", 32'd0, 32'd1);
      tick();
      bus.in_valid = 1'b0;
   endtask

   task automatic do_start();
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
   endtask

   task automatic clear_log();
      wa.delete();
      wd.delete();
      wc.delete();
      ndone = 0;
   endtask

   task automatic wait_idle();
      int t;
      t = 0;
      while (bus.busy && t < 2000) begin
         tick();
         t++;
      end
      chk("idle_timeout", {31'd0, bus.busy}, 32'd0);
      tick();
   endtask

   initial begin
      logic [7:0] b;
      logic [7:0] csum;
      int bad;

      bus.start    = 1'b0;
      bus.in_valid = 1'b0;
      bus.in_data  = 8'd0;
      rst_n        = 1'b1;
      #12;
      chk("reset_outputs", {bus.in_ready, bus.ld_we, bus.ld_addr, bus.ld_data,
                            bus.busy, bus.done, bus.err, bus.wr_count}, 32'd0);

      // good checksum, back-to-back stream; start presented together with reset release
      @(posedge clk);
      #1;
      clear_log();
      rst_n     = 1'b0;
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      chk("first_start_busy", {31'd0, bus.busy}, 32'd1);
      chk("first_start_ready", {31'd0, bus.in_ready}, 32'd1);
      send(8'h03); send(8'h11); send(8'h22); send(8'h33); send(8'h00);
      wait_idle();
      chk("s1_nwrites", wa.size(), 32'd3);
      for (int i = 0; i < wa.size() && i < 3; i++) begin
         chk($sformatf("s1_addr%0d", i), {25'd0, wa[i]}, i);
      end
      if (wd.size() == 3) begin
         chk("s1_data0", {24'd0, wd[0]}, 32'h11);
         chk("s1_data1", {24'd0, wd[1]}, 32'h22);
         chk("s1_data2", {24'd0, wd[2]}, 32'h33);
         chk("s1_consec", wc[2] - wc[0], 32'd2);
      end
      chk("s1_done", ndone, 32'd1);
      chk("s1_err", {31'd0, bus.err}, 32'd0);
      chk("s1_wr_count", {24'd0, bus.wr_count}, 32'd3);
      chk("s1_hold", {bus.ld_we, bus.ld_addr, bus.ld_data}, {17'd0, 7'd2, 8'h33});

      // checksum mismatch
      clear_log();
      do_start();
      send(8'h02); send(8'hAA); send(8'h55); send(8'h00);
      wait_idle();
      chk("s2_nwrites", wa.size(), 32'd2);
      if (wa.size() == 2) begin
         chk("s2_w0", {17'd0, wa[0], wd[0]}, {17'd0, 7'd0, 8'hAA});
         chk("s2_w1", {17'd0, wa[1], wd[1]}, {17'd0, 7'd1, 8'h55});
      end
      chk("s2_done", ndone, 32'd0);
      chk("s2_err", {31'd0, bus.err}, 32'd1);
      chk("s2_wr_count", {24'd0, bus.wr_count}, 32'd2);
      chk("s2_busy", {31'd0, bus.busy}, 32'd0);

      // illegal lengths 00 and 81
      clear_log();
      do_start();
      chk("s3_err_cleared", {31'd0, bus.err}, 32'd0);
      send(8'h00);
      wait_idle();
      chk("s3a_err", {31'd0, bus.err}, 32'd1);
      chk("s3a_busy", {31'd0, bus.busy}, 32'd0);
      do_start();
      send(8'h81);
      wait_idle();
      chk("s3b_err", {31'd0, bus.err}, 32'd1);
      chk("s3b_busy", {31'd0, bus.busy}, 32'd0);
      chk("s3_nwrites", wa.size(), 32'd0);
      chk("s3_wr_count", {24'd0, bus.wr_count}, 32'd0);
      chk("s3_done", ndone, 32'd0);

      // full 128-byte load with random valid gaps
      clear_log();
      do_start();
      send(8'h80);
      csum = 8'h00;
      for (int i = 0; i < 128; i++) begin
         b = 8'(i * 7 + 3);
         csum = csum ^ b;
         repeat ($urandom_range(0, 3)) tick();
         send(b);
      end
      repeat ($urandom_range(0, 3)) tick();
      send(csum);
      wait_idle();
      chk("s4_nwrites", wa.size(), 32'd128);
      bad = 0;
      for (int i = 0; i < wa.size() && i < 128; i++) begin
         if (wa[i] !== 7'(i) || wd[i] !== 8'(i * 7 + 3)) bad++;
      end
      chk("s4_bad_writes", bad, 32'd0);
      if (wa.size() == 128) chk("s4_last_addr", {25'd0, wa[127]}, 32'h7F);
      chk("s4_done", ndone, 32'd1);
      chk("s4_err", {31'd0, bus.err}, 32'd0);
      chk("s4_wr_count", {24'd0, bus.wr_count}, 32'h80);

      // asynchronous reset in the middle of a session
      clear_log();
      do_start();
      send(8'h04); send(8'h01); send(8'h02);
      chk("s5_pre_rst_we", {31'd0, bus.ld_we}, 32'd1);
      #2;
      rst_n = 1'b1;
      #1;
      chk("s5_async_rst", {bus.in_ready, bus.ld_we, bus.ld_addr, bus.ld_data,
                           bus.busy, bus.done, bus.err, bus.wr_count}, 32'd0);
      #3;
      rst_n = 1'b0;
      tick();
      clear_log();
      do_start();
      send(8'h01); send(8'h5A); send(8'h5A);
      wait_idle();
      chk("s5_nwrites", wa.size(), 32'd1);
      if (wa.size() == 1) chk("s5_w0", {17'd0, wa[0], wd[0]}, {17'd0, 7'd0, 8'h5A});
      chk("s5_done", ndone, 32'd1);
      chk("s5_err", {31'd0, bus.err}, 32'd0);
      chk("s5_wr_count", {24'd0, bus.wr_count}, 32'd1);

      // start pulsed during DATA is ignored
      clear_log();
      do_start();
      send(8'h03); send(8'h10);
      bus.start = 1'b1;
      send(8'h20);
      bus.start = 1'b0;
      send(8'h40); send(8'h70);
      wait_idle();
      chk("s6_nwrites", wa.size(), 32'd3);
      if (wa.size() == 3) chk("s6_w2", {17'd0, wa[2], wd[2]}, {17'd0, 7'd2, 8'h40});
      chk("s6_done", ndone, 32'd1);
      chk("s6_err", {31'd0, bus.err}, 32'd0);
      chk("s6_wr_count", {24'd0, bus.wr_count}, 32'd3);

      chk("done_err_overlap", nboth, 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
